// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Imported by the unit itself and by the control logic that drives Op.
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StFin  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issuing control unit (master) and muldiv_unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             Start;
  op_e              Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivZero, Hi, Lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Owns the architectural Hi/Lo registers; they update only on the Done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic     Clk,
  input logic     Reset,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign signed_op = ~bus.Op[0];
  assign a_neg     = signed_op & bus.A[WIDTH-1];
  assign b_neg     = signed_op & bus.B[WIDTH-1];
  assign a_mag     = a_neg ? -bus.A : bus.A;
  assign b_mag     = b_neg ? -bus.B : bus.B;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // Divide: acc = {remainder, dividend/quotient}; rem_sh carries the guard bit.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - b_q;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    acc_d     = acc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          is_div_d  = bus.Op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = CntW'(WIDTH - 1);
          busy_d    = 1'b1;
          if (bus.Op[1]) begin
            state_d = StDiv;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
          end else begin
            state_d = StMul;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            b_d     = a_mag;
          end
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFin;
      end
      StDiv: begin
        if (b_q == '0) begin
          state_d = StFin;
        end else begin
          acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected Hi/Lo/DivZero built from
// 64-bit reference arithmetic, plus latency, Busy and pulse-width checks.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi, m_lo;
  int           compared, mismatched;

  function automatic exp_t model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo);
    exp_t         e;
    logic [2*W-1:0] p;
    longint       sa, sb, ua, ub, q, r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'({{W{1'b0}}, a});
    ub   = longint'({{W{1'b0}}, b});
    e.hi = prev_hi;
    e.lo = prev_lo;
    e.dz = 1'b0;
    case (op)
      OpMult:  begin p = sa * sb; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
      OpMultu: begin p = ua * ub; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
      OpDiv: begin
        if (b == '0) e.dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; e.lo = q[W-1:0]; e.hi = r[W-1:0]; end
      end
      default: begin
        if (b == '0) e.dz = 1'b1;
        else begin q = ua / ub; r = ua % ub; e.lo = q[W-1:0]; e.hi = r[W-1:0]; end
      end
    endcase
    return e;
  endfunction

  // Drive one request at a negedge; returns #1 after the sampling edge with inputs scrambled.
  task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    e = model(op, a, b, m_hi, m_lo);
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.A     = $urandom();
    bus.B     = $urandom();
    bus.Op    = op_e'(2'($urandom()));
  endtask

  // Counts edges until Done (cycles = -1 on timeout); busy_ok drops if Busy fell early.
  task automatic wait_done(output int cycles, output logic busy_ok);
    logic seen;
    seen    = 1'b0;
    cycles  = 0;
    busy_ok = 1'b1;
    while (!seen && cycles < 200) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      @(posedge Clk);
      #1;
      cycles++;
      if (bus.Done === 1'b1) seen = 1'b1;
    end
    if (!seen) cycles = -1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    compared++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.DivZero !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got busy=%b done=%b dz=%b want 0 0 0",
               bus.Busy, bus.Done, bus.DivZero);
    end
    compared++;
    if (bus.Hi !== '0 || bus.Lo !== '0) begin
      mismatched++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", bus.Hi, bus.Lo);
    end
    Reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
  endtask

  task automatic test_mult_signed();
    int cyc; logic bok; exp_t e;
    issue(OpMult, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if (cyc != W + 1) begin
      mismatched++; $display("FAIL mult_latency: got %0d want %0d", cyc, W + 1);
    end
    compared++;
    if (!bok || bus.Busy !== 1'b0) begin
      mismatched++; $display("FAIL mult_busy: busy_held=%b busy_at_done=%b want 1 0", bok, bus.Busy);
    end
    compared++;
    if ({bus.Hi, bus.Lo, bus.DivZero} !== {e.hi, e.lo, e.dz}) begin
      mismatched++;
      $display("FAIL mult_result: got %h/%h dz=%b want %h/%h dz=%b",
               bus.Hi, bus.Lo, bus.DivZero, e.hi, e.lo, e.dz);
    end
    @(posedge Clk); #1;
    compared++;
    if (bus.Done !== 1'b0) begin
      mismatched++; $display("FAIL done_pulse: got %b want 0", bus.Done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic bok; exp_t e;
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if ({bus.Hi, bus.Lo} !== {e.hi, e.lo}) begin
      mismatched++; $display("FAIL multu_result: got %h/%h want %h/%h", bus.Hi, bus.Lo, e.hi, e.lo);
    end
    issue(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002);
    compared++;
    if (bus.Busy !== 1'b1) begin
      mismatched++; $display("FAIL b2b_accept: got busy=%b want 1", bus.Busy);
    end
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if (cyc != W + 1 || !bok) begin
      mismatched++; $display("FAIL b2b_latency: got %0d busy_held=%b want %0d 1", cyc, bok, W + 1);
    end
    compared++;
    if ({bus.Hi, bus.Lo, bus.DivZero} !== {e.hi, e.lo, e.dz}) begin
      mismatched++;
      $display("FAIL b2b_div_result: got %h/%h dz=%b want %h/%h dz=%b",
               bus.Hi, bus.Lo, bus.DivZero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_divzero();
    int cyc; logic bok; exp_t e;
    issue(OpDivu, 32'h5678_1234, 32'h0001_0000);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if ({bus.Hi, bus.Lo} !== {e.hi, e.lo}) begin
      mismatched++; $display("FAIL divu_setup: got %h/%h want %h/%h", bus.Hi, bus.Lo, e.hi, e.lo);
    end
    issue(OpDivu, 32'h0000_0007, 32'h0000_0000);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if (cyc != 2 || !bok) begin
      mismatched++; $display("FAIL divzero_latency: got %0d busy_held=%b want 2 1", cyc, bok);
    end
    compared++;
    if ({bus.Hi, bus.Lo, bus.DivZero} !== {e.hi, e.lo, e.dz}) begin
      mismatched++;
      $display("FAIL divzero_result: got %h/%h dz=%b want %h/%h dz=%b",
               bus.Hi, bus.Lo, bus.DivZero, e.hi, e.lo, e.dz);
    end
    @(posedge Clk); #1;
    compared++;
    if (bus.DivZero !== 1'b0 || bus.Done !== 1'b0) begin
      mismatched++; $display("FAIL divzero_pulse: got dz=%b done=%b want 0 0", bus.DivZero, bus.Done);
    end
  endtask

  task automatic test_div_overflow();
    int cyc; logic bok; exp_t e;
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if ({bus.Hi, bus.Lo, bus.DivZero} !== {e.hi, e.lo, e.dz}) begin
      mismatched++;
      $display("FAIL div_minneg: got %h/%h dz=%b want %h/%h dz=%b",
               bus.Hi, bus.Lo, bus.DivZero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt, done_at; logic [W-1:0] hi_s, lo_s; exp_t e;
    done_cnt = 0;
    done_at  = -1;
    hi_s     = '0;
    lo_s     = '0;
    issue(OpMult, 32'h1234_5678, 32'hFFFF_0001);
    for (int c = 1; c <= int'(W) + 20; c++) begin
      if (c == 10) begin
        bus.Start = 1'b1; bus.Op = OpDivu; bus.A = 32'd1; bus.B = 32'd1;
      end
      if (c == 11) bus.Start = 1'b0;
      @(posedge Clk); #1;
      if (bus.Done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = c; hi_s = bus.Hi; lo_s = bus.Lo; end
      end
    end
    e = sb_q.pop_front();
    compared++;
    if (done_cnt != 1 || done_at != int'(W) + 1) begin
      mismatched++;
      $display("FAIL busy_start_done: got count=%0d at=%0d want 1 at %0d", done_cnt, done_at, W + 1);
    end
    compared++;
    if ({hi_s, lo_s} !== {e.hi, e.lo}) begin
      mismatched++; $display("FAIL busy_start_result: got %h/%h want %h/%h", hi_s, lo_s, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, stray; logic bok; exp_t e;
    issue(OpDivu, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (14) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    compared++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Hi !== '0 || bus.Lo !== '0) begin
      mismatched++;
      $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.Busy, bus.Done, bus.Hi, bus.Lo);
    end
    @(negedge Clk);
    Reset = 1'b0;
    void'(sb_q.pop_back());
    m_hi  = '0;
    m_lo  = '0;
    stray = 0;
    repeat (W + 8) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1) stray++;
    end
    compared++;
    if (stray != 0) begin
      mismatched++; $display("FAIL reset_no_done: got %0d Done pulses want 0", stray);
    end
    issue(OpDivu, 32'd100, 32'd7);
    wait_done(cyc, bok);
    e = sb_q.pop_front();
    compared++;
    if (cyc != W + 1 || {bus.Hi, bus.Lo} !== {e.hi, e.lo}) begin
      mismatched++;
      $display("FAIL post_reset_divu: got %0d cyc %h/%h want %0d cyc %h/%h",
               cyc, bus.Hi, bus.Lo, W + 1, e.hi, e.lo);
    end
  endtask

  task automatic test_random();
    int cyc, want_cyc; logic bok; exp_t e; op_e op; logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = op_e'(2'($urandom_range(0, 3)));
      a  = $urandom();
      b  = $urandom();
      if (i % 4 == 1) b = b >> $urandom_range(16, 31);
      if (i == 5) b = '0;
      if (i == 7) begin a = 32'h8000_0000; b = 32'h0000_0003; end
      want_cyc = (op[1] && b == '0) ? 2 : int'(W) + 1;
      issue(op, a, b);
      wait_done(cyc, bok);
      e = sb_q.pop_front();
      compared++;
      if (cyc != want_cyc || !bok) begin
        mismatched++;
        $display("FAIL rand%0d_latency: got %0d busy_held=%b want %0d 1", i, cyc, bok, want_cyc);
      end
      compared++;
      if ({bus.Hi, bus.Lo, bus.DivZero} !== {e.hi, e.lo, e.dz}) begin
        mismatched++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h/%h dz=%b want %h/%h dz=%b",
                 i, op, a, b, bus.Hi, bus.Lo, bus.DivZero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_hi       = '0;
    m_lo       = '0;
    bus.Start  = 1'b0;
    bus.Op     = OpMult;
    bus.A      = '0;
    bus.B      = '0;
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_divzero();
    test_div_overflow();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 32: operand width; legal values are even and 8..64.
REQ-003 Port Clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous active-high reset.
REQ-005 Port Start, input, 1 bit: request; sampled only when idle or when Done is high.
REQ-006 Port Op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-007 Port A, input, WIDTH bits: multiplicand or dividend; sampled with Start.
REQ-008 Port B, input, WIDTH bits: multiplier or divisor; sampled with Start.
REQ-009 Port Busy, output, 1 bit: an operation is in progress.
REQ-010 Port Done, output, 1 bit: one-cycle pulse; Hi/Lo hold the new result in the same cycle.
REQ-011 Port DivZero, output, 1 bit: one-cycle pulse coincident with Done; the divisor was zero.
REQ-012 Port Hi, output, WIDTH bits: product high half, or remainder.
REQ-013 Port Lo, output, WIDTH bits: product low half, or quotient.

Function
REQ-014 The FSM SHALL have four states: IDLE, MUL, DIV, FIN.
REQ-015 IDLE, or Done high, with Start=1: capture Op/A/B; next state MUL (Op=0x) or DIV (Op=1x); iteration counter <= WIDTH-1.
REQ-016 DIV with B=0: the next state SHALL be FIN directly, with no iterations.
REQ-017 MUL: one radix-2 shift-add step per cycle on |A|,|B| (signed ops) or A,B (unsigned); 2*WIDTH accumulator.
REQ-018 DIV: one restoring-division step per cycle on magnitudes; WIDTH-bit remainder plus one guard bit.
REQ-019 MUL/DIV: decrement the counter each cycle; move to FIN after the step taken at count 0.
REQ-020 FIN: apply sign correction, write Hi/Lo, pulse Done for exactly one cycle, then go to IDLE.
REQ-021 Latency: Start sampled at edge k -> Done high after edge k+WIDTH+1. Divide-by-zero: Done after edge k+2.
REQ-022 Busy SHALL be high after edge k through the edge that raises Done, and low while Done is high.
REQ-023 Signed product: two's-complement 2*WIDTH result; negate when sign(A) xor sign(B).
REQ-024 Signed divide: the quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-025 Signed divide, minimum negative / -1: Lo = minimum negative (wrap), Hi = 0; no flag.
REQ-026 Divide by zero: DivZero=1 with Done; Hi/Lo keep their previous values.
REQ-027 Hi/Lo SHALL change only in the Done cycle; otherwise they hold the last result.
REQ-028 Start while Busy SHALL be ignored, with no effect on the in-flight operation.
REQ-029 Start in the Done cycle SHALL be accepted (back-to-back operation); the next Done follows per REQ-021.
REQ-030 A and B may change after the sample edge without affecting the result.

Reset
REQ-031 Reset SHALL force state IDLE; Busy, Done, DivZero = 0; Hi, Lo, accumulator, counter = 0.
REQ-032 Reset mid-operation SHALL abort the operation; no Done is produced.
REQ-033 The first Start sampled after Reset deasserts SHALL behave per REQ-015.

Structure
REQ-034 Package muldiv_pkg SHALL hold the Op encoding enum (MULT, MULTU, DIV, DIVU) and the FSM state enum.
REQ-035 muldiv_pkg SHALL hold the default WIDTH constant, shared with the control unit that drives Op.
REQ-036 The block SHALL be a single module with no sub-modules; the magnitude/negate logic stays inline.
REQ-037 The Hi/Lo output registers SHALL live inside this block; the CPU drops its separate mult/div units and Hi/Lo muxes.

Verification (WIDTH=32)
REQ-038 MULT A=FFFFFFFD, B=00000005 -> Done after edge k+33; Hi=FFFFFFFF, Lo=FFFFFFF1.
REQ-039 MULTU A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; then back-to-back DIV -7/2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
REQ-040 DIVU A=7, B=0, with prior Hi/Lo=1234/5678 -> Done and DivZero after edge k+2; Hi/Lo stay 1234/5678.
REQ-041 DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=00000000, DivZero=0.
REQ-042 Start pulse at cycle 10 of a MULT -> ignored; a single Done with the original result.
REQ-043 Reset at cycle 15 of a DIVU -> Busy=0, Hi=Lo=0, no Done; then DIVU 100/7 -> Lo=14, Hi=2.
